// File: rtl/nv_nvdla_mcif_read_eg_lat_fifo_ctrl.sv
// Control stage of the MCIF read-egress latency FIFO: drives an external DEPTH-entry
// flop RAM and a registered one-entry output stage, for DEPTH+1 beats of total capacity.
module nv_nvdla_mcif_read_eg_lat_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 512
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [2:0]    lat_fifo_cnt,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd_in,
    output logic [31:0]   pwrbus_ram_pd
);

    localparam logic [2:0] RAM_FULL = 3'(DEPTH);

    logic [AW-1:0] wr_adr_q, wr_adr_d;
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic [2:0]    ram_cnt_q, ram_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] rd_pd_q, rd_pd_d;
    logic          push, load, pop_out;

    always_comb begin
        push      = wr_pvld & wr_prdy;
        // Refill the output register whenever it is empty or draining this cycle.
        load      = (ram_cnt_q != 3'd0) & (~out_vld_q | rd_prdy);
        pop_out   = out_vld_q & rd_prdy;

        wr_adr_d  = wr_adr_q;
        rd_adr_d  = rd_adr_q;
        ram_cnt_d = ram_cnt_q;
        out_vld_d = out_vld_q;
        rd_pd_d   = rd_pd_q;

        if (push) wr_adr_d = wr_adr_q + AW'(1);
        if (load) begin
            rd_adr_d  = rd_adr_q + AW'(1);
            rd_pd_d   = ram_dout;
            out_vld_d = 1'b1;
        end else if (pop_out) begin
            out_vld_d = 1'b0;
        end

        if (push & ~load)      ram_cnt_d = ram_cnt_q + 3'd1;
        else if (load & ~push) ram_cnt_d = ram_cnt_q - 3'd1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_adr_q  <= '0;
            rd_adr_q  <= '0;
            ram_cnt_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_adr_q  <= wr_adr_d;
            rd_adr_q  <= rd_adr_d;
            ram_cnt_q <= ram_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Payload register carries no reset; it is only meaningful while rd_pvld is high.
    always_ff @(posedge nvdla_core_clk) begin
        rd_pd_q <= rd_pd_d;
    end

    // Ready ignores a same-cycle drain so it stays a pure function of state.
    assign wr_prdy       = (ram_cnt_q != RAM_FULL);
    assign ram_we        = push;
    assign ram_wa        = wr_adr_q;
    assign ram_di        = wr_pd;
    assign ram_ra        = rd_adr_q;
    assign rd_pvld       = out_vld_q;
    assign rd_pd         = rd_pd_q;
    assign lat_fifo_cnt  = ram_cnt_q + {2'b00, out_vld_q};
    assign pwrbus_ram_pd = pwrbus_ram_pd_in;

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_lat_fifo_ctrl.sv
// Directed bench for the latency FIFO control: behavioural RAM, scoreboard queue,
// immediate assertions at every comparison point.
module tb_nv_nvdla_mcif_read_eg_lat_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 512;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we;
    logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
    logic [2:0]    lat_fifo_cnt;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [31:0]   pwr_in, pwr_out;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] wa_m;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            sent     = 0;
    int            tgt      = 0;
    int            used;

    always #5 clk = ~clk;

    nv_nvdla_mcif_read_eg_lat_fifo_ctrl dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .wr_pvld          (wr_pvld),
        .wr_prdy          (wr_prdy),
        .wr_pd            (wr_pd),
        .rd_pvld          (rd_pvld),
        .rd_prdy          (rd_prdy),
        .rd_pd            (rd_pd),
        .lat_fifo_cnt     (lat_fifo_cnt),
        .ram_we           (ram_we),
        .ram_wa           (ram_wa),
        .ram_di           (ram_di),
        .ram_ra           (ram_ra),
        .ram_dout         (ram_dout),
        .pwrbus_ram_pd_in (pwr_in),
        .pwrbus_ram_pd    (pwr_out)
    );

    always_ff @(posedge clk) if (ram_we) mem[ram_wa] <= ram_di;
    assign ram_dout = mem[ram_ra];

    function automatic logic [DW-1:0] beat(input int n);
        return {16{32'(n) + 32'h1000_0000}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle per iteration, entered and left at posedge+1.
    task automatic stream(input int add, input int wpct, input int rpct, input int maxc,
                          input bit drain, output int cyc);
        logic          fw, fr, hold;
        logic [DW-1:0] pd_prev, wd;
        tgt += add;
        cyc = 0;
        while (cyc < maxc && !(sent == tgt && exp_q.size() == 0)) begin
            if (!wr_pvld) begin
                wr_pvld = (sent < tgt) && ($urandom_range(99) < wpct);
                wr_pd   = beat(sent);
            end
            rd_prdy = ($urandom_range(99) < rpct);
            #1;
            fw = wr_pvld & wr_prdy;
            fr = rd_pvld & rd_prdy;
            hold = rd_pvld & !rd_prdy;
            pd_prev = rd_pd;
            wd = wr_pd;
            if (fw) begin
                chk("ram_wa", DW'(ram_wa), DW'(wa_m));
                chk("ram_di", ram_di, wd);
            end
            chk("ram_we", DW'(ram_we), DW'(fw));
            @(posedge clk); #1;
            cyc++;
            if (fr) chk("rd_order", pd_prev, exp_q.pop_front());
            if (fw) begin
                exp_q.push_back(wd);
                sent++;
                wa_m++;
                wr_pvld = 1'b0;
            end
            if (hold) begin
                chk("hold_vld", DW'(rd_pvld), DW'(1));
                chk("hold_pd", rd_pd, pd_prev);
            end
            chk("lat_cnt", DW'(lat_fifo_cnt), DW'(exp_q.size()));
        end
        if (drain) begin
            chk("drained", DW'(exp_q.size()), DW'(0));
            chk("all_sent", DW'(sent), DW'(tgt));
        end
    endtask

    initial begin
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0; pwr_in = 32'h5A5A_0F0F;
        wa_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_rd_pvld", DW'(rd_pvld), DW'(0));
        chk("rst_cnt", DW'(lat_fifo_cnt), DW'(0));
        chk("rst_wr_prdy", DW'(wr_prdy), DW'(1));
        chk("rst_ram_we", DW'(ram_we), DW'(0));
        chk("pwrbus", DW'(pwr_out), DW'(32'h5A5A_0F0F));

        // Single beat: visible two cycles after the push, gone after the pop
        wr_pd = {64{8'hA5}}; wr_pvld = 1'b1; rd_prdy = 1'b1; #1;
        chk("t1_we", DW'(ram_we), DW'(1));
        chk("t1_wa", DW'(ram_wa), DW'(0));
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        chk("t1_vld_c2", DW'(rd_pvld), DW'(0));
        chk("t1_cnt_c2", DW'(lat_fifo_cnt), DW'(1));
        @(posedge clk); #1;
        chk("t1_vld_c3", DW'(rd_pvld), DW'(1));
        chk("t1_pd_c3", rd_pd, {64{8'hA5}});
        chk("t1_cnt_c3", DW'(lat_fifo_cnt), DW'(1));
        @(posedge clk); #1;
        chk("t1_vld_c4", DW'(rd_pvld), DW'(0));
        chk("t1_cnt_c4", DW'(lat_fifo_cnt), DW'(0));
        wa_m = AW'(1);

        // Fill to capacity with downstream stalled; sixth beat held off
        stream(6, 100, 0, 7, 1'b0, used);
        chk("full_cnt", DW'(lat_fifo_cnt), DW'(5));
        chk("full_prdy", DW'(wr_prdy), DW'(0));
        chk("full_vld", DW'(rd_pvld), DW'(1));
        chk("full_d0", rd_pd, beat(0));
        chk("full_sent", DW'(sent), DW'(5));

        // Full RAM with downstream ready: push stalls this cycle, accepted next
        rd_prdy = 1'b1; #1;
        chk("stall_prdy", DW'(wr_prdy), DW'(0));
        chk("stall_we", DW'(ram_we), DW'(0));
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        chk("stall_next_prdy", DW'(wr_prdy), DW'(1));
        chk("stall_next_we", DW'(ram_we), DW'(1));
        chk("stall_next_pd", rd_pd, beat(1));
        chk("stall_next_cnt", DW'(lat_fifo_cnt), DW'(4));
        stream(0, 100, 100, 20, 1'b1, used);

        // Sustained one beat per cycle across several pointer wraps
        stream(20, 100, 100, 40, 1'b1, used);
        chk("thru_cycles", DW'(used), DW'(22));

        // Random traffic against the scoreboard
        stream(1000, 50, 50, 12000, 1'b1, used);

        // Asynchronous reset mid-operation
        stream(3, 100, 0, 3, 1'b0, used);
        chk("pre_rst_cnt", DW'(lat_fifo_cnt), DW'(3));
        #2 rstn = 1'b0;
        #1;
        chk("arst_vld", DW'(rd_pvld), DW'(0));
        chk("arst_cnt", DW'(lat_fifo_cnt), DW'(0));
        chk("arst_prdy", DW'(wr_prdy), DW'(1));
        wr_pvld = 1'b0;
        exp_q.delete();
        sent = tgt;
        wa_m = '0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        stream(1, 100, 100, 6, 1'b1, used);
        chk("post_rst_cycles", DW'(used), DW'(3));
        chk("post_rst_cnt", DW'(lat_fifo_cnt), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_mcif_read_eg_lat_fifo_ctrl.md
Name: nv_nvdla_mcif_read_eg_lat_fifo_ctrl

Overview:
Control stage of the MCIF read-egress latency FIFO. It accepts 512-bit read-return beats with a valid/ready handshake and stores them in the external 4x512 flop RAM by driving its write-enable, write-address and read-address. It registers the RAM read data into a one-entry output stage and presents it downstream with a valid/ready handshake. The RAM holds 4 beats and the output register holds 1, so total capacity is 5.

Parameters:
DEPTH, 4, number of RAM entries (power of two)
AW, 2, RAM address width, log2(DEPTH)
DW, 512, payload width

Ports:
nvdla_core_clk  input  1  core clock; all state updates on the rising edge
nvdla_core_rstn  input  1  reset, asynchronous assert, active-low
wr_pvld  input  1  upstream beat valid
wr_prdy  output  1  upstream ready
wr_pd  input  DW  upstream payload
rd_pvld  output  1  downstream beat valid
rd_prdy  input  1  downstream ready
rd_pd  output  DW  downstream payload (registered)
lat_fifo_cnt  output  3  total occupancy, RAM plus output register, 0..5
ram_we  output  1  RAM write enable
ram_wa  output  AW  RAM write address
ram_di  output  DW  RAM write data
ram_ra  output  AW  RAM read address (combinational read)
ram_dout  input  DW  RAM read data for ram_ra
pwrbus_ram_pd_in  input  32  RAM power-down bus
pwrbus_ram_pd  output  32  direct pass-through of pwrbus_ram_pd_in

Behaviour:
- Clocking and reset: single clock domain (nvdla_core_clk). nvdla_core_rstn asserts asynchronously and is active-low.
- State: wr_adr[AW-1:0], rd_adr[AW-1:0], ram_cnt[2:0] (0..4), out_vld (drives rd_pvld), rd_pd register.
- Reset values: wr_adr=0, rd_adr=0, ram_cnt=0, rd_pvld=0, lat_fifo_cnt=0. rd_pd is not reset and is don't-care while rd_pvld=0. After reset, wr_prdy=1.
- wr_prdy = (ram_cnt != DEPTH).
  - Combinational from ram_cnt only.
  - It does not account for a same-cycle RAM drain, so a full RAM stalls for one cycle after draining.
- push = wr_pvld & wr_prdy. On push:
  - ram_we=1, ram_wa=wr_adr, ram_di=wr_pd.
  - The RAM captures the beat at the same edge.
  - wr_adr increments modulo DEPTH (3 wraps to 0).
  - When push=0, ram_we=0, and ram_wa/ram_di are don't-care.
- ram_ra = rd_adr at all times.
- pop_out = rd_pvld & rd_prdy.
- load = (ram_cnt != 0) & (!rd_pvld | rd_prdy). On load:
  - rd_pd <= ram_dout.
  - rd_adr increments modulo DEPTH.
  - rd_pvld <= 1.
- When pop_out & !load: rd_pvld <= 0.
- ram_cnt next = ram_cnt + push - load. Push and load in the same cycle leave ram_cnt unchanged. Push and load never address the same stale entry, because load uses only entries already counted.
- lat_fifo_cnt = ram_cnt + rd_pvld (registered state, no combinational path from inputs).
- Latency: a beat pushed in cycle t appears with rd_pvld=1 in cycle t+2 when the FIFO is empty and downstream is ready. Zero-cycle bypass is not provided.
- Throughput: 1 beat/cycle sustained when rd_prdy=1 continuously.
- Ordering: strict FIFO; no data reordering or drop.
- Backpressure:
  - rd_pd and rd_pvld hold stable while rd_pvld=1 and rd_prdy=0.
  - The upstream must hold wr_pd stable while wr_pvld=1 and wr_prdy=0.
- Asynchronous reset mid-operation discards all contents. Pointers return to 0 immediately and rd_pvld drops without waiting for a clock edge.
- Pushing with wr_prdy=0 has no effect; ram_we stays 0.

Test Plan:
- Reset, then push one beat 0xA5..A5 in cycle 1 with rd_prdy=1 -> ram_we=1 and ram_wa=0 in cycle 1; rd_pvld=1 and rd_pd=0xA5..A5 in cycle 3; lat_fifo_cnt returns to 0 after the pop.
- rd_prdy=0, push beats D0..D5 back-to-back -> D0..D4 accepted (4 in RAM, 1 in output register), lat_fifo_cnt=5, wr_prdy=0 while D5 is held; release rd_prdy -> D0..D5 emerge in order, D0 first.
- Continuous push and rd_prdy=1 for 20 beats -> one beat per cycle after a 2-cycle fill; wr_adr and rd_adr wrap 3->0 five times; data is in order.
- Random wr_pvld/rd_prdy (50% each) for 1000 beats against a scoreboard -> no loss, duplication or reorder; rd_pd stable whenever rd_pvld & !rd_prdy.
- Fill to lat_fifo_cnt=3, assert nvdla_core_rstn=0 between clock edges -> rd_pvld=0 and lat_fifo_cnt=0 immediately; after release, the first push is written to ram_wa=0 and emerges alone.
- RAM full (ram_cnt=4) with rd_prdy=1 and a push presented -> push is stalled that cycle and accepted the next cycle; ram_cnt stays at or below 4 throughout.
